ahb_slave_if: RTL and testbench

//  AHB-side front end of the AHB-to-APB bridge; sits directly upstream of apb_controller.
//  - Qualifies AHB address phases into a single 'valid' strobe.
//  - Pipelines address, data and write-direction into two register stages for the controller.
//  - Decodes the APB slave select and returns read data to the master.
//  - Generates the two-cycle AHB ERROR response for unmapped addresses and merges HREADYOUT.

---
 rtl/ahb_apb_pkg.sv | 24 ++
 rtl/ahb_slave_if_if.sv | 23 ++
 rtl/ahb_addr_decode.sv | 35 +++
 rtl/ahb_slave_if.sv | 112 +++++++++++
 tb/tb_ahb_slave_if.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/ahb_apb_pkg.sv
// Shared codes for the AHB-to-APB bridge: HTRANS/HRESP values, APB slave
// select patterns and the AHB error-response state encoding.
package ahb_apb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  localparam logic [2:0] TSEL_NONE = 3'b000;
  localparam logic [2:0] TSEL_S0   = 3'b001;
  localparam logic [2:0] TSEL_S1   = 3'b010;
  localparam logic [2:0] TSEL_S2   = 3'b100;

  typedef enum logic [1:0] {
    E_OKAY = 2'd0,
    E_ERR1 = 2'd1,
    E_ERR2 = 2'd2
  } err_state_t;

endpackage

// File: rtl/ahb_slave_if_if.sv
// AHB master-facing signal bundle of the bridge front end.
interface ahb_bus_if;

  logic        Hwrite;
  logic        Hreadyin;
  logic [1:0]  Htrans;
  logic [31:0] Haddr;
  logic [31:0] Hwdata;
  logic [31:0] Hrdata;
  logic [1:0]  Hresp;
  logic        Hreadyout;

  modport master (
    output Hwrite, Hreadyin, Htrans, Haddr, Hwdata,
    input  Hrdata, Hresp, Hreadyout
  );

  modport slave (
    input  Hwrite, Hreadyin, Htrans, Haddr, Hwdata,
    output Hrdata, Hresp, Hreadyout
  );

endinterface

// File: rtl/ahb_addr_decode.sv
// Combinational address decoder: reports whether an address falls inside the
// bridge window and which APB slave (one-hot) it belongs to.
module ahb_addr_decode #(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter logic [31:0] SLV_SPAN  = 32'h0400_0000,
  parameter int unsigned NUM_SLV   = 3
) (
  input  logic [31:0] addr,
  output logic        mapped,
  output logic [2:0]  tsel
);

  // 33-bit arithmetic keeps the window end from wrapping past 2^32
  localparam logic [32:0] BASE33 = {1'b0, BASE_ADDR};
  localparam logic [32:0] SPAN33 = {1'b0, SLV_SPAN};
  localparam logic [32:0] END33  = BASE33 + SPAN33 * 33'(NUM_SLV);

  logic [32:0] addr33;
  logic [32:0] off;

  // Window check, then pick the slave whose span contains the offset
  always_comb begin
    addr33 = {1'b0, addr};
    off    = addr33 - BASE33;
    mapped = (addr33 >= BASE33) && (addr33 < END33);
    tsel   = '0;
    if (mapped) begin
      for (int unsigned i = 0; i < 3; i++) begin
        if ((i < NUM_SLV) && (off >= SPAN33 * 33'(i)) && (off < SPAN33 * 33'(i + 1)))
          tsel[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ahb_slave_if.sv
// AHB-side front end of the AHB-to-APB bridge: qualifies address phases,
// pipelines address/data/direction for the APB controller, decodes the slave
// select, passes read data back and produces the two-cycle ERROR response.
module ahb_slave_if
  import ahb_apb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter logic [31:0] SLV_SPAN  = 32'h0400_0000,
  parameter int unsigned NUM_SLV   = 3
) (
  input  logic        Hclk,
  input  logic        Hreset,
  ahb_bus_if.slave    ahb,
  input  logic [31:0] Prdata,
  input  logic        apb_hreadyout,
  output logic        valid,
  output logic [31:0] Haddr1,
  output logic [31:0] Haddr2,
  output logic [31:0] Hwdata1,
  output logic [31:0] Hwdata2,
  output logic        Hwrite_reg,
  output logic [2:0]  tsel
);

  err_state_t err_state;
  err_state_t err_next;

  logic       mapped_in;
  logic [2:0] tsel_in;
  logic       mapped1;
  logic       active;
  logic       hresp_err;
  logic       hready_out;

  // Each decoder instance only needs one of its two outputs
  logic unused_dec;
  assign unused_dec = &{1'b0, tsel_in, mapped1};

  ahb_addr_decode #(
    .BASE_ADDR (BASE_ADDR),
    .SLV_SPAN  (SLV_SPAN),
    .NUM_SLV   (NUM_SLV)
  ) u_dec_haddr (
    .addr   (ahb.Haddr),
    .mapped (mapped_in),
    .tsel   (tsel_in)
  );

  ahb_addr_decode #(
    .BASE_ADDR (BASE_ADDR),
    .SLV_SPAN  (SLV_SPAN),
    .NUM_SLV   (NUM_SLV)
  ) u_dec_haddr1 (
    .addr   (Haddr1),
    .mapped (mapped1),
    .tsel   (tsel)
  );

  assign active    = ahb.Hreadyin & ahb.Htrans[1];
  assign valid     = active & mapped_in & (err_state != E_ERR1);
  assign ahb.Hrdata = Prdata;

  // Address/data/direction pipeline; advances only while the bus is ready
  always_ff @(posedge Hclk or posedge Hreset) begin
    if (Hreset) begin
      Haddr1     <= '0;
      Haddr2     <= '0;
      Hwdata1    <= '0;
      Hwdata2    <= '0;
      Hwrite_reg <= 1'b0;
    end else if (ahb.Hreadyin) begin
      Haddr1     <= ahb.Haddr;
      Haddr2     <= Haddr1;
      Hwdata1    <= ahb.Hwdata;
      Hwdata2    <= Hwdata1;
      Hwrite_reg <= ahb.Hwrite;
    end
  end

  // Error-response state register
  always_ff @(posedge Hclk or posedge Hreset) begin
    if (Hreset) err_state <= E_OKAY;
    else        err_state <= err_next;
  end

  // Error FSM next state and merged HRESP/HREADYOUT
  always_comb begin
    err_next   = err_state;
    hresp_err  = 1'b0;
    hready_out = apb_hreadyout;
    case (err_state)
      E_OKAY: begin
        if (active && !mapped_in) err_next = E_ERR1;
      end
      E_ERR1: begin
        hresp_err  = 1'b1;
        hready_out = 1'b0;
        err_next   = E_ERR2;
      end
      E_ERR2: begin
        hresp_err  = 1'b1;
        hready_out = 1'b1;
        err_next   = (active && !mapped_in) ? E_ERR1 : E_OKAY;
      end
      default: err_next = E_OKAY;
    endcase
  end

  assign ahb.Hresp     = hresp_err ? HRESP_ERROR : HRESP_OKAY;
  assign ahb.Hreadyout = hready_out;

endmodule

// File: tb/tb_ahb_slave_if.sv
// Bench for ahb_slave_if: directed scenarios followed by random traffic, all
// checked against a history-based reference model of the bridge front end.
module tb_ahb_slave_if;

  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam logic [31:0] SPAN = 32'h0400_0000;

  logic        Hclk;
  logic        Hreset;
  logic [31:0] Prdata;
  logic        apb_hreadyout;
  logic        valid;
  logic [31:0] Haddr1, Haddr2, Hwdata1, Hwdata2;
  logic        Hwrite_reg;
  logic [2:0]  tsel;

  ahb_bus_if bus ();

  ahb_slave_if #(
    .BASE_ADDR (BASE),
    .SLV_SPAN  (SPAN),
    .NUM_SLV   (3)
  ) dut (
    .Hclk          (Hclk),
    .Hreset        (Hreset),
    .ahb           (bus.slave),
    .Prdata        (Prdata),
    .apb_hreadyout (apb_hreadyout),
    .valid         (valid),
    .Haddr1        (Haddr1),
    .Haddr2        (Haddr2),
    .Hwdata1       (Hwdata1),
    .Hwdata2       (Hwdata2),
    .Hwrite_reg    (Hwrite_reg),
    .tsel          (tsel)
  );

  initial Hclk = 1'b0;
  always #5 Hclk = ~Hclk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: newest accepted beat at index 0
  logic [31:0] h_addr[$];
  logic [31:0] h_wdata[$];
  logic        h_write[$];
  int          err_age;   // cycles into an error response: 0 none, 1 first, 2 second

  function automatic bit in_window(input logic [31:0] a);
    longint la = longint'(a);
    return (la >= longint'(BASE)) && (la < longint'(BASE) + 3 * longint'(SPAN));
  endfunction

  function automatic logic [2:0] slave_of(input logic [31:0] a);
    longint idx;
    if (!in_window(a)) return 3'b000;
    idx = (longint'(a) - longint'(BASE)) / longint'(SPAN);
    return 3'(1 << idx);
  endfunction

  function automatic logic [31:0] hist32(input logic [31:0] q[$], input int k);
    return (q.size() > k) ? q[k] : 32'h0;
  endfunction

  task automatic model_reset();
    h_addr.delete();
    h_wdata.delete();
    h_write.delete();
    err_age = 0;
  endtask

  // One bus cycle: called at posedge+1, leaves at the next posedge+1
  task automatic step(input logic rdy, input logic [1:0] tr, input logic [31:0] a,
                      input logic wr, input logic [31:0] wd);
    logic [31:0] e_a1;
    bit          exp_valid;
    bus.Hreadyin  = rdy;
    bus.Htrans    = tr;
    bus.Haddr     = a;
    bus.Hwrite    = wr;
    bus.Hwdata    = wd;
    Prdata        = $urandom;
    apb_hreadyout = 1'($urandom_range(0, 1));
    #2;
    exp_valid = rdy && tr[1] && in_window(a) && (err_age != 1);
    check("valid", 32'(valid), 32'(exp_valid));
    check("hrdata", bus.Hrdata, Prdata);
    check("hresp", 32'(bus.Hresp), (err_age != 0) ? 32'd1 : 32'd0);
    check("hreadyout", 32'(bus.Hreadyout),
          (err_age == 1) ? 32'd0 : (err_age == 2) ? 32'd1 : 32'(apb_hreadyout));
    @(posedge Hclk);
    if (rdy) begin
      h_addr.push_front(a);
      h_wdata.push_front(wd);
      h_write.push_front(wr);
      if (h_addr.size() > 2) begin
        void'(h_addr.pop_back());
        void'(h_wdata.pop_back());
        void'(h_write.pop_back());
      end
    end
    if (err_age == 1) err_age = 2;
    else if (rdy && tr[1] && !in_window(a)) err_age = 1;
    else err_age = 0;
    #1;
    e_a1 = hist32(h_addr, 0);
    check("haddr1", Haddr1, e_a1);
    check("haddr2", Haddr2, hist32(h_addr, 1));
    check("hwdata1", Hwdata1, hist32(h_wdata, 0));
    check("hwdata2", Hwdata2, hist32(h_wdata, 1));
    check("hwrite_reg", 32'(Hwrite_reg), (h_write.size() > 0) ? 32'(h_write[0]) : 32'd0);
    check("tsel", 32'(tsel), 32'(slave_of(e_a1)));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_haddr1"}, Haddr1, 32'h0);
    check({tag, "_haddr2"}, Haddr2, 32'h0);
    check({tag, "_hwdata1"}, Hwdata1, 32'h0);
    check({tag, "_hwdata2"}, Hwdata2, 32'h0);
    check({tag, "_hwrite_reg"}, 32'(Hwrite_reg), 32'h0);
    check({tag, "_tsel"}, 32'(tsel), 32'h0);
    check({tag, "_hresp"}, 32'(bus.Hresp), 32'h0);
  endtask

  logic [31:0] edge_addrs [8];

  initial begin
    edge_addrs[0] = 32'h8000_0000; edge_addrs[1] = 32'h83FF_FFFC;
    edge_addrs[2] = 32'h8400_0000; edge_addrs[3] = 32'h8BFF_FFFC;
    edge_addrs[4] = 32'h8C00_0000; edge_addrs[5] = 32'h7FFF_FFFC;
    edge_addrs[6] = 32'hFFFF_FFFC; edge_addrs[7] = 32'h0000_0000;

    Hreset = 1'b1;
    bus.Hreadyin = 1'b0; bus.Htrans = 2'b00; bus.Haddr = '0;
    bus.Hwrite = 1'b0; bus.Hwdata = '0; Prdata = '0; apb_hreadyout = 1'b0;
    model_reset();
    @(posedge Hclk);
    #1;
    check_all_zero("rst");
    check("rst_hreadyout", 32'(bus.Hreadyout), 32'd0);
    Hreset = 1'b0;

    // Write transfer followed by its data phase
    step(1, 2'b10, 32'h8000_0010, 1, 32'h0);
    check("wr_tsel", 32'(tsel), 32'b001);
    check("wr_hwrite_reg", 32'(Hwrite_reg), 32'd1);
    step(1, 2'b00, 32'h0000_0000, 0, 32'hDEAD_BEEF);
    check("wr_hwdata1", Hwdata1, 32'hDEAD_BEEF);
    check("wr_haddr2", Haddr2, 32'h8000_0010);
    step(1, 2'b00, 32'h0000_0000, 0, 32'h0);

    // Decode at window and slave boundaries
    step(1, 2'b10, 32'h8400_0000, 0, 32'h1);
    check("dec_s1", 32'(tsel), 32'b010);
    step(1, 2'b11, 32'h8BFF_FFFC, 0, 32'h2);
    check("dec_s2", 32'(tsel), 32'b100);
    step(1, 2'b00, 32'h0, 0, 32'h0);
    step(1, 2'b10, 32'h8C00_0000, 0, 32'h3);
    step(1, 2'b00, 32'h0, 0, 32'h0);
    step(1, 2'b10, 32'h7FFF_FFFC, 0, 32'h4);
    step(1, 2'b00, 32'h0, 0, 32'h0);

    // Single error response
    step(1, 2'b10, 32'h9000_0000, 0, 32'h0);
    step(0, 2'b00, 32'h0, 0, 32'h0);
    step(1, 2'b00, 32'h0, 0, 32'h0);
    step(1, 2'b00, 32'h0, 0, 32'h0);

    // Back-to-back errors, then a mapped transfer straight out of ERR2
    step(1, 2'b10, 32'h9000_0000, 0, 32'h0);
    step(0, 2'b00, 32'h0, 0, 32'h0);
    step(1, 2'b10, 32'hA000_0000, 1, 32'h0);
    step(0, 2'b00, 32'h0, 0, 32'h0);
    step(1, 2'b10, 32'h8000_0100, 1, 32'h55);
    step(1, 2'b00, 32'h0, 0, 32'h66);

    // Stall with the address changing underneath
    step(1, 2'b10, 32'h8000_0200, 1, 32'h1111);
    step(1, 2'b10, 32'h8400_0300, 1, 32'h2222);
    step(0, 2'b10, 32'h8800_0400, 0, 32'h3333);
    step(0, 2'b11, 32'h8000_0500, 1, 32'h4444);
    step(0, 2'b10, 32'h9000_0600, 0, 32'h5555);
    check("stall_haddr1", Haddr1, 32'h8400_0300);
    check("stall_hwdata2", Hwdata2, 32'h1111);
    step(1, 2'b00, 32'h0, 0, 32'h7777);

    // Asynchronous reset in the middle of an error response
    step(1, 2'b10, 32'hC000_0000, 1, 32'hABCD);
    #2;
    bus.Hreadyin = 1'b1; bus.Htrans = 2'b10; bus.Haddr = 32'h8000_0040;
    bus.Hwdata = 32'h1234_5678;
    Hreset = 1'b1;
    #1;
    model_reset();
    check_all_zero("arst");
    apb_hreadyout = 1'b1;
    #1;
    check("arst_hreadyout1", 32'(bus.Hreadyout), 32'd1);
    apb_hreadyout = 1'b0;
    #1;
    check("arst_hreadyout0", 32'(bus.Hreadyout), 32'd0);
    @(posedge Hclk);
    #1;
    check_all_zero("arst_hold");
    Hreset = 1'b0;

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      logic [31:0] a;
      case ($urandom_range(0, 3))
        0: a = $urandom;
        1: a = BASE + ($urandom % (3 * SPAN));
        2: a = edge_addrs[$urandom_range(0, 7)];
        default: a = BASE + ($urandom % (3 * SPAN)) + (($urandom_range(0, 1) == 1) ? 32'h1000_0000 : 32'h0);
      endcase
      step(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), a,
           1'($urandom_range(0, 1)), $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
